// File: rtl/bsg_nor3_serial_collector.sv
// Collects operands three at a time over a ready/valid link and presents the
// bitwise NOR of each group on a registered valid/yumi output.
module bsg_nor3_serial_collector #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    typedef enum logic [1:0] {
        BEAT_0 = 2'd0,
        BEAT_1 = 2'd1,
        BEAT_2 = 2'd2
    } beat_e;

    beat_e              beat_r, beat_n;
    logic [width_p-1:0] acc_r, acc_n;
    logic [width_p-1:0] data_r, data_n;
    logic               v_r, v_n;
    logic               accept;

    // The closing beat may only land when the output register is free or
    // is being drained in this same cycle.
    assign ready_o = reset_n_i & ((beat_r != BEAT_2) | ~v_r | yumi_i);
    assign accept  = v_i & ready_o;
    assign v_o     = v_r;
    assign data_o  = data_r;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through this block can leave one unassigned and infer a latch.
        beat_n = beat_r;
        acc_n  = acc_r;
        data_n = data_r;
        v_n    = v_r;

        if (yumi_i) begin
            v_n = 1'b0;
        end

        if (accept) begin
            case (beat_r)
                BEAT_0: begin
                    acc_n  = data_i;
                    beat_n = BEAT_1;
                end
                BEAT_1: begin
                    acc_n  = acc_r | data_i;
                    beat_n = BEAT_2;
                end
                BEAT_2: begin
                    data_n = ~(acc_r | data_i);
                    v_n    = 1'b1;
                    acc_n  = '0;
                    beat_n = BEAT_0;
                end
                default: begin
                    acc_n  = '0;
                    beat_n = BEAT_0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            beat_r <= BEAT_0;
            acc_r  <= '0;
            v_r    <= 1'b0;
            data_r <= '0;
        end else begin
            beat_r <= beat_n;
            acc_r  <= acc_n;
            v_r    <= v_n;
            data_r <= data_n;
        end
    end

endmodule
